// File: rtl/ex_stage_pkg.sv
// Shared constants for the execute stage: ALU op codes, data2 sources,
// default control values, muldiv engine states and op decode helpers.
package ex_stage_pkg;

    localparam logic [3:0] AluAdd  = 4'd0;
    localparam logic [3:0] AluSub  = 4'd1;
    localparam logic [3:0] AluAnd  = 4'd2;
    localparam logic [3:0] AluOr   = 4'd3;
    localparam logic [3:0] AluXor  = 4'd4;
    localparam logic [3:0] AluNor  = 4'd5;
    localparam logic [3:0] AluSll  = 4'd6;
    localparam logic [3:0] AluSrl  = 4'd7;
    localparam logic [3:0] AluSra  = 4'd8;
    localparam logic [3:0] AluSlt  = 4'd9;
    localparam logic [3:0] AluSltu = 4'd10;
    localparam logic [3:0] AluLui  = 4'd11;
    localparam logic [3:0] AluMul  = 4'd12;
    localparam logic [3:0] AluDivu = 4'd13;
    localparam logic [3:0] AluRemu = 4'd14;
    localparam logic [3:0] AluPass = 4'd15;

    localparam logic [1:0] Src2Reg  = 2'd0;
    localparam logic [1:0] Src2Imm  = 2'd1;
    localparam logic [1:0] Src2Pc   = 2'd2;
    localparam logic [1:0] Src2Zero = 2'd3;

    localparam logic [2:0] DefaultMemOp       = 3'd0;
    localparam logic [4:0] DefaultWriteRegDst = 5'd0;

    // Multi-cycle op codes; equal to ALUoperation[1:0] for ops 12..14.
    localparam logic [1:0] MdMul  = 2'd0;
    localparam logic [1:0] MdDivu = 2'd1;
    localparam logic [1:0] MdRemu = 2'd2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    function automatic logic is_multi(input logic [3:0] op);
        return (op == AluMul) || (op == AluDivu) || (op == AluRemu);
    endfunction

endpackage

// File: rtl/ex_stage_iter_muldiv.sv
// Iterative 32-step engine: shift-add multiply (low word) and restoring
// unsigned divide/remainder, with divide-by-zero resolved at start.
module iter_muldiv
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        start_i,
    input  logic        ack_i,
    input  logic [1:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        done_o,
    output logic [31:0] result_o
);

    logic [1:0]  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] acc_q, acc_d;   // product accumulator / partial remainder
    logic [31:0] quo_q, quo_d;   // multiplier bits / dividend-to-quotient
    logic [31:0] opnd_q, opnd_d; // shifting multiplicand / divisor
    logic [32:0] rem_shift;
    logic [32:0] diff;

    always_comb begin
        rem_shift = {acc_q, quo_q[31]};
        diff      = rem_shift - {1'b0, opnd_q};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        opnd_d  = opnd_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    op_d  = op_i;
                    cnt_d = 5'd0;
                    if (op_i == MdMul) begin
                        acc_d   = 32'h0;
                        quo_d   = b_i;
                        opnd_d  = a_i;
                        state_d = StBusy;
                    end else if (b_i == 32'h0) begin
                        acc_d   = a_i;
                        quo_d   = 32'hFFFF_FFFF;
                        opnd_d  = 32'h0;
                        state_d = StDone;
                    end else begin
                        acc_d   = 32'h0;
                        quo_d   = a_i;
                        opnd_d  = b_i;
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (op_q == MdMul) begin
                    if (quo_q[0]) begin
                        acc_d = acc_q + opnd_q;
                    end
                    opnd_d = {opnd_q[30:0], 1'b0};
                    quo_d  = {1'b0, quo_q[31:1]};
                end else if (!diff[32]) begin
                    acc_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    acc_d = rem_shift[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (ack_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = 5'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= 5'd0;
            op_q    <= MdMul;
            acc_q   <= 32'h0;
            quo_q   <= 32'h0;
            opnd_q  <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            opnd_q  <= opnd_d;
        end
    end

    assign busy_o   = (state_q == StBusy);
    assign done_o   = (state_q == StDone);
    assign result_o = (op_q == MdDivu) ? quo_q : acc_q;

endmodule

// File: rtl/ex_stage.sv
// Execute stage: data2 mux, single-cycle ALU, multi-cycle op sequencing
// through iter_muldiv, and MEM/WB control forwarding with flush/reset kill.
module ex_stage
    import ex_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcPlusOne_i,
    input  logic [31:0] reg1Data_i,
    input  logic [31:0] reg2Data_i,
    input  logic [31:0] imm_i,
    input  logic [3:0]  ALUoperation_i,
    input  logic [1:0]  ALUdata2Src_i,
    input  logic        ALUToReg_i,
    input  logic        MemToReg_i,
    input  logic [2:0]  MemOp_i,
    input  logic [4:0]  WriteRegDst_i,
    input  logic        RegWrite_i,
    input  logic        advance_i,
    input  logic        flush_i,
    output logic [31:0] aluResult_o,
    output logic [31:0] memWriteData_o,
    output logic        ALUToReg_o,
    output logic        MemToReg_o,
    output logic [2:0]  MemOp_o,
    output logic [4:0]  WriteRegDst_o,
    output logic        RegWrite_o,
    output logic        exStall_o
);

    logic [31:0] data2;
    logic [31:0] alu_res;
    logic [31:0] md_result;
    logic        md_busy;
    logic        md_done;
    logic        multi_op;
    logic        md_start;

    always_comb begin
        unique case (ALUdata2Src_i)
            Src2Reg: data2 = reg2Data_i;
            Src2Imm: data2 = imm_i;
            Src2Pc:  data2 = pcPlusOne_i;
            default: data2 = 32'h0;
        endcase
    end

    always_comb begin
        alu_res = 32'h0;
        case (ALUoperation_i)
            AluAdd:  alu_res = reg1Data_i + data2;
            AluSub:  alu_res = reg1Data_i - data2;
            AluAnd:  alu_res = reg1Data_i & data2;
            AluOr:   alu_res = reg1Data_i | data2;
            AluXor:  alu_res = reg1Data_i ^ data2;
            AluNor:  alu_res = ~(reg1Data_i | data2);
            AluSll:  alu_res = reg1Data_i << data2[4:0];
            AluSrl:  alu_res = reg1Data_i >> data2[4:0];
            AluSra:  alu_res = $unsigned($signed(reg1Data_i) >>> data2[4:0]);
            AluSlt:  alu_res = {31'h0, $signed(reg1Data_i) < $signed(data2)};
            AluSltu: alu_res = {31'h0, reg1Data_i < data2};
            AluLui:  alu_res = {data2[15:0], 16'h0};
            AluPass: alu_res = data2;
            default: alu_res = 32'h0;
        endcase
    end

    assign multi_op = is_multi(ALUoperation_i);
    assign md_start = multi_op && !md_busy && !md_done && !flush_i;

    iter_muldiv u_iter_muldiv (
        .clk      (clk),
        .rst      (rst),
        .clear_i  (flush_i),
        .start_i  (md_start),
        .ack_i    (advance_i),
        .op_i     (ALUoperation_i[1:0]),
        .a_i      (reg1Data_i),
        .b_i      (data2),
        .busy_o   (md_busy),
        .done_o   (md_done),
        .result_o (md_result)
    );

    always_comb begin
        ALUToReg_o     = ALUToReg_i;
        MemToReg_o     = MemToReg_i;
        MemOp_o        = MemOp_i;
        WriteRegDst_o  = WriteRegDst_i;
        RegWrite_o     = RegWrite_i;
        memWriteData_o = reg2Data_i;
        exStall_o      = md_busy || md_start;
        if (md_done) begin
            aluResult_o = md_result;
        end else if (multi_op) begin
            aluResult_o = 32'h0;
        end else begin
            aluResult_o = alu_res;
        end
        if (rst) begin
            ALUToReg_o     = 1'b0;
            MemToReg_o     = 1'b0;
            MemOp_o        = DefaultMemOp;
            WriteRegDst_o  = DefaultWriteRegDst;
            RegWrite_o     = 1'b0;
            memWriteData_o = 32'h0;
            exStall_o      = 1'b0;
            aluResult_o    = 32'h0;
        end else if (flush_i) begin
            RegWrite_o = 1'b0;
            MemOp_o    = DefaultMemOp;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage: ALU ops, forwarding, multi-cycle
// latency, divide by zero, DONE hold, flush and reset mid-operation.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pcPlusOne_i, reg1Data_i, reg2Data_i, imm_i;
    logic [3:0]  ALUoperation_i;
    logic [1:0]  ALUdata2Src_i;
    logic        ALUToReg_i, MemToReg_i, RegWrite_i, advance_i, flush_i;
    logic [2:0]  MemOp_i;
    logic [4:0]  WriteRegDst_i;
    logic [31:0] aluResult_o, memWriteData_o;
    logic        ALUToReg_o, MemToReg_o, RegWrite_o, exStall_o;
    logic [2:0]  MemOp_o;
    logic [4:0]  WriteRegDst_o;

    int checks = 0;
    int errors = 0;

    ex_stage dut (
        .clk            (clk),
        .rst            (rst),
        .pcPlusOne_i    (pcPlusOne_i),
        .reg1Data_i     (reg1Data_i),
        .reg2Data_i     (reg2Data_i),
        .imm_i          (imm_i),
        .ALUoperation_i (ALUoperation_i),
        .ALUdata2Src_i  (ALUdata2Src_i),
        .ALUToReg_i     (ALUToReg_i),
        .MemToReg_i     (MemToReg_i),
        .MemOp_i        (MemOp_i),
        .WriteRegDst_i  (WriteRegDst_i),
        .RegWrite_i     (RegWrite_i),
        .advance_i      (advance_i),
        .flush_i        (flush_i),
        .aluResult_o    (aluResult_o),
        .memWriteData_o (memWriteData_o),
        .ALUToReg_o     (ALUToReg_o),
        .MemToReg_o     (MemToReg_o),
        .MemOp_o        (MemOp_o),
        .WriteRegDst_o  (WriteRegDst_o),
        .RegWrite_o     (RegWrite_o),
        .exStall_o      (exStall_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [3:0] op, input logic [1:0] src, input logic [31:0] r1,
                          input logic [31:0] r2, input logic [31:0] imm);
        ALUoperation_i = op;
        ALUdata2Src_i  = src;
        reg1Data_i     = r1;
        reg2Data_i     = r2;
        imm_i          = imm;
    endtask

    task automatic alu_vec(input string tag, input logic [3:0] op, input logic [1:0] src,
                           input logic [31:0] r1, input logic [31:0] r2,
                           input logic [31:0] imm, input logic [31:0] exp);
        set_op(op, src, r1, r2, imm);
        #1;
        check_eq(tag, aluResult_o, exp);
        check_eq({tag, "_stall"}, 32'(exStall_o), 32'h0);
        tick();
    endtask

    // Counts stall-high cycles from the start cycle; leaves the DUT in DONE.
    task automatic run_multi(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic adv, input int exp_n,
                             input logic [31:0] exp_res);
        int n;
        set_op(op, Src2Reg, a, b, 32'h0);
        advance_i = adv;
        n = 0;
        #1;
        while (exStall_o && n < 100) begin
            n++;
            @(posedge clk);
            #1;
        end
        check_eq({tag, "_cycles"}, 32'(n), 32'(exp_n));
        check_eq({tag, "_result"}, aluResult_o, exp_res);
    endtask

    task automatic leave_done();
        advance_i = 1'b1;
        tick();
        set_op(AluAdd, Src2Zero, 32'h0, 32'h0, 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        flush_i = 1'b0;
        advance_i = 1'b1;
        pcPlusOne_i = 32'h0000_0040;
        set_op(AluAdd, Src2Reg, 32'h11, 32'h1234, 32'h0);
        ALUToReg_i = 1'b1;
        MemToReg_i = 1'b1;
        MemOp_i = 3'd5;
        WriteRegDst_i = 5'd7;
        RegWrite_i = 1'b1;
        tick();
        tick();
        #1;
        check_eq("rst_result", aluResult_o, 32'h0);
        check_eq("rst_stall", 32'(exStall_o), 32'h0);
        check_eq("rst_regwrite", 32'(RegWrite_o), 32'h0);
        check_eq("rst_memop", 32'(MemOp_o), 32'(DefaultMemOp));
        check_eq("rst_memtoreg", 32'(MemToReg_o), 32'h0);
        check_eq("rst_alutoreg", 32'(ALUToReg_o), 32'h0);
        check_eq("rst_wdst", 32'(WriteRegDst_o), 32'h0);
        check_eq("rst_memwdata", memWriteData_o, 32'h0);
        rst = 1'b0;
        #1;
        check_eq("fwd_regwrite", 32'(RegWrite_o), 32'h1);
        check_eq("fwd_memop", 32'(MemOp_o), 32'h5);
        check_eq("fwd_wdst", 32'(WriteRegDst_o), 32'h7);
        check_eq("fwd_memtoreg", 32'(MemToReg_o), 32'h1);
        check_eq("fwd_memwdata", memWriteData_o, 32'h1234);
        flush_i = 1'b1;
        #1;
        check_eq("flush_regwrite", 32'(RegWrite_o), 32'h0);
        check_eq("flush_memop", 32'(MemOp_o), 32'(DefaultMemOp));
        check_eq("flush_wdst", 32'(WriteRegDst_o), 32'h7);
        flush_i = 1'b0;
        tick();

        alu_vec("add_wrap", AluAdd, Src2Imm, 32'h7FFF_FFFF, 32'h0, 32'h1, 32'h8000_0000);
        alu_vec("sub", AluSub, Src2Reg, 32'h5, 32'h7, 32'h0, 32'hFFFF_FFFE);
        alu_vec("nor", AluNor, Src2Reg, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0, 32'h0000_0F0F);
        alu_vec("sll", AluSll, Src2Imm, 32'h0000_0003, 32'h0, 32'h24, 32'h0000_0030);
        alu_vec("sra", AluSra, Src2Reg, 32'h8000_0000, 32'h4, 32'h0, 32'hF800_0000);
        alu_vec("srl", AluSrl, Src2Reg, 32'h8000_0000, 32'h4, 32'h0, 32'h0800_0000);
        alu_vec("slt", AluSlt, Src2Reg, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h1);
        alu_vec("sltu", AluSltu, Src2Reg, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0);
        alu_vec("lui", AluLui, Src2Imm, 32'h0, 32'h0, 32'h0000_1234, 32'h1234_0000);
        alu_vec("pass_pc", AluPass, Src2Pc, 32'h0, 32'h0, 32'h0, 32'h0000_0040);
        alu_vec("or_zero", AluOr, Src2Zero, 32'hA5A5_0000, 32'hFFFF_FFFF, 32'h0, 32'hA5A5_0000);

        run_multi("mul", AluMul, 32'h0001_0003, 32'h0000_0005, 1'b1, 33, 32'h0005_000F);
        leave_done();
        run_multi("divu", AluDivu, 32'd100, 32'd7, 1'b1, 33, 32'd14);
        leave_done();
        run_multi("remu", AluRemu, 32'd100, 32'd7, 1'b1, 33, 32'd2);
        leave_done();
        run_multi("divu0", AluDivu, 32'd5, 32'd0, 1'b1, 1, 32'hFFFF_FFFF);
        leave_done();
        run_multi("remu0", AluRemu, 32'd5, 32'd0, 1'b1, 1, 32'd5);
        leave_done();

        run_multi("mul_hold", AluMul, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 32'h0000_0001);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_result", aluResult_o, 32'h0000_0001);
            check_eq("hold_stall", 32'(exStall_o), 32'h0);
        end
        leave_done();
        tick();

        set_op(AluMul, Src2Reg, 32'h3, 32'h4, 32'h0);
        #1;
        repeat (10) tick();
        check_eq("busy_stall", 32'(exStall_o), 32'h1);
        flush_i = 1'b1;
        #1;
        check_eq("busy_flush_regwrite", 32'(RegWrite_o), 32'h0);
        tick();
        flush_i = 1'b0;
        set_op(AluAdd, Src2Reg, 32'd3, 32'd4, 32'h0);
        #1;
        check_eq("post_flush_stall", 32'(exStall_o), 32'h0);
        check_eq("post_flush_add", aluResult_o, 32'd7);
        tick();

        set_op(AluMul, Src2Reg, 32'h3, 32'h4, 32'h0);
        #1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        check_eq("rst_busy_stall", 32'(exStall_o), 32'h0);
        check_eq("rst_busy_result", aluResult_o, 32'h0);
        check_eq("rst_busy_regwrite", 32'(RegWrite_o), 32'h0);
        check_eq("rst_busy_wdst", 32'(WriteRegDst_o), 32'h0);
        rst = 1'b0;
        set_op(AluXor, Src2Reg, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'h0);
        #1;
        check_eq("post_rst_stall", 32'(exStall_o), 32'h0);
        check_eq("post_rst_xor", aluResult_o, 32'hF00F_F00F);
        tick();
        run_multi("mul_after_rst", AluMul, 32'd6, 32'd7, 1'b1, 33, 32'd42);
        leave_done();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the 32-bit five-stage pipeline. It sits between the ID/EX pipeline register and the EX/MEM register, consumes the registered ID/EX data and control, and produces the ALU result plus forwarded MEM/WB control. Single-cycle ops resolve combinationally. MUL/DIVU/REMU run on an iterative 32-step engine that holds the pipeline through `exStall_o` until the result is ready.

## Interface
- No parameters. Widths are fixed at 32-bit data, 5-bit register index, 4-bit ALU op.
- `clk  in  1`: the single clock; all state updates on its rising edge.
- `rst  in  1`: synchronous, active-high reset.
- `pcPlusOne_i, reg1Data_i, reg2Data_i, imm_i  in  32 each`: ID/EX data.
- `ALUoperation_i  in  4`, `ALUdata2Src_i  in  2`, `ALUToReg_i  in  1`: EX control.
- `MemToReg_i  in  1`, `MemOp_i  in  3`, `WriteRegDst_i  in  5`, `RegWrite_i  in  1`: MEM/WB control.
- `advance_i  in  1`: EX/MEM captures this cycle (hazard unit not stalling EX/MEM).
- `flush_i  in  1`: kill the instruction currently in EX.
- `aluResult_o  out  32`: execute result.
- `memWriteData_o  out  32`: equals `reg2Data_i`.
- `ALUToReg_o, MemToReg_o, MemOp_o, WriteRegDst_o, RegWrite_o  out`: forwarded control, same widths as the inputs.
- `exStall_o  out  1`: hold IF/ID and ID/EX, bubble EX/MEM.

## Operation
- data2 source by `ALUdata2Src_i`:
  - 0: `reg2Data_i`
  - 1: `imm_i`
  - 2: `pcPlusOne_i`
  - 3: 32'h0
- `ALUoperation_i` encoding, single-cycle ops:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOR
  - 6 SLL, 7 SRL, 8 SRA: `reg1Data_i` shifted by data2[4:0]
  - 9 SLT (signed), 10 SLTU: result 32'h1 or 32'h0
  - 11 LUI: data2<<16
  - 15 PASS: data2
- `ALUoperation_i` encoding, multi-cycle ops:
  - 12 MUL: low 32 bits of the product
  - 13 DIVU: unsigned quotient
  - 14 REMU: unsigned remainder
- Arithmetic wraps modulo 2^32. No overflow trap.
- FSM states:
  - IDLE: single-cycle ops pass through; `exStall_o` = 0.
  - IDLE with a multi-cycle op and no `flush_i`: `exStall_o` = 1 combinationally. Latch operands and op, clear counter. Go to BUSY, or straight to DONE if the op is DIVU/REMU and data2 == 0.
  - BUSY: one shift-add (MUL) or restoring-subtract (DIVU/REMU) step per cycle. `exStall_o` = 1. After step 31 go to DONE.
  - DONE: `exStall_o` = 0; `aluResult_o` = result register. Stay in DONE until `advance_i`, then go to IDLE.
- Divide by zero: quotient 32'hFFFFFFFF, remainder = dividend.
- `flush_i` in any state: next state IDLE, counter cleared. In the flush cycle, `RegWrite_o` = 0 and `MemOp_o` = `DEFAULT_memOp`. In IDLE, a flushed multi-cycle op does not start.
- `rst` takes priority over `flush_i`.
- During `rst`:
  - forced: `aluResult_o` = 0, `exStall_o` = 0, `RegWrite_o` = 0, `MemOp_o` = `DEFAULT_memOp`, `MemToReg_o` = 0, `ALUToReg_o` = 0, `WriteRegDst_o` = 0, `memWriteData_o` = 0.
  - internal state: FSM = IDLE; counter and result register cleared.
- Outside reset and flush, forwarded control equals its inputs in every state. While stalled, the EX/MEM bubble keeps them from taking effect.

## Timing
- Single-cycle ops: zero added latency; result valid in the cycle the op is presented.
- MUL, DIVU/REMU with nonzero divisor:
  - cycle 0 (IDLE start) plus 32 BUSY cycles: `exStall_o` high for 33 cycles.
  - result on `aluResult_o` in cycle 33 (DONE), with stall low.
- DIVU/REMU with zero divisor: stall high for 1 cycle; result in cycle 1.
- DONE held under `!advance_i`: result stays stable and stall stays low until `advance_i`.
- Back-to-back multi-cycle ops: the second one starts in the cycle after DONE+`advance_i`. There is no IDLE gap beyond that.
- `flush_i` or `rst` while BUSY: `exStall_o` is low in the following cycle.

## Structure
- ALU op codes (0–15), data2 source codes, and `DEFAULT_*` control values go in the shared `defines.v`.
- One sub-module, `iter_muldiv`:
  - ports: start, op, operand A, operand B
  - outputs: busy, done, result
  - contains the counter, accumulator/remainder and quotient registers
- `ex_stage` holds the combinational ALU, data2 mux, FSM glue and control forwarding.

## Test plan
- ADD 32'h7FFFFFFF + imm 1 (`ALUdata2Src_i` = 1) -> `aluResult_o` = 32'h80000000 same cycle; `exStall_o` = 0.
- SRA of reg1 32'h80000000 by reg2 4 -> 32'hF8000000. SLT -1 vs 1 -> 1. SLTU same operands -> 0.
- MUL 32'h0001_0003 × 32'h0000_0005 with `advance_i` = 1 -> stall high for exactly 33 cycles, then result 32'h0005_000F.
- DIVU 100/7 -> quotient 14 at cycle 33. REMU 100/7 -> 2. DIVU 5/0 -> 32'hFFFFFFFF after 1 stall cycle. REMU 5/0 -> 5.
- MUL started, `flush_i` at BUSY cycle 10 -> stall low next cycle, FSM IDLE. A following ADD completes normally.
- MUL reaching DONE with `advance_i` = 0 for 3 cycles -> result held stable, stall low. `rst` mid-BUSY -> all outputs at reset values next cycle.
